// File: rtl/cla_pkg.sv
// Shared definitions for the CLA adder exhaustive self-test checker:
// FSM encoding, vector/error widths and the golden 5-bit sum.
package cla_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int VEC_W    = 9;
    localparam int VEC_LAST = 511;
    localparam int ERR_W    = 10;

    // Zero-extended so the carry-out lands in bit 4 instead of being dropped.
    function automatic logic [4:0] ref_sum(input logic [3:0] a, input logic [3:0] b,
                                           input logic c0);
        return {1'b0, a} + {1'b0, b} + {4'b0, c0};
    endfunction
endpackage

// File: rtl/cla_bist_checker.sv
// Exhaustive BIST for an external 4-bit CLA adder: sweeps all {c0,b,a}
// vectors, holds each for SETTLE cycles, then compares against the golden sum.
module cla_bist_checker
    import cla_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       a_o,
    output logic [3:0]       b_o,
    output logic             c0_o,
    input  logic [3:0]       sum_i,
    input  logic             c4_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_valid,
    output logic [VEC_W-1:0] fail_vec
);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [VEC_W-1:0] IDX_LAST    = VEC_W'(VEC_LAST);

    state_t           state;
    logic [VEC_W-1:0] idx;
    logic [3:0]       settle_cnt;
    logic             mismatch;

    // Operands come straight from the index register, so the adder sees
    // stable inputs for the whole settle window.
    assign a_o  = idx[3:0];
    assign b_o  = idx[7:4];
    assign c0_o = idx[8];

    assign mismatch = ({c4_i, sum_i} != ref_sum(a_o, b_o, c0_o));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        settle_cnt <= '0;
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= idx;
                        end
                    end
                    if (idx == IDX_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + VEC_W'(1);
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    // err_cnt already includes the final vector's result here.
                    done  <= 1'b0;
                    pass  <= (err_cnt == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_bist_checker.sv
// Scoreboard bench: behavioural adder with injectable faults drives two
// checker instances (SETTLE=1 and SETTLE=3); a monitor checks each done pulse.
module tb_cla_bist_checker;
    typedef struct {
        int err;
        int fv;
        int fvec;
        int pass;
        int lat;
        int start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0, start3 = 1'b0;
    int   cyc = 0;
    int   total = 0, bad = 0;
    int   fmode = 0, bad_idx = 0;
    int   issued1 = 0, retired1 = 0, issued3 = 0, retired3 = 0;
    exp_t q1[$], q3[$];

    logic [3:0] a1, b1, s1, a3, b3, s3;
    logic       c01, c41, c03, c43;
    logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
    logic [9:0] err1, err3;
    logic [8:0] fvec1, fvec3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External adder model with optional fault: 1=sum[0] stuck 0,
    // 2=c4 stuck 0, 3=one corrupted vector at bad_idx.
    function automatic logic [4:0] adder(input int a, input int b, input int c, input int mode,
                                         input int bidx);
        logic [4:0] r;
        r = 5'(a + b + c);
        case (mode)
            1: r[0] = 1'b0;
            2: r[4] = 1'b0;
            3: if ((c * 256 + b * 16 + a) == bidx) r = r ^ 5'h05;
            default: ;
        endcase
        return r;
    endfunction

    assign {c41, s1} = adder(int'(a1), int'(b1), int'(c01), fmode, bad_idx);
    assign {c43, s3} = adder(int'(a3), int'(b3), int'(c03), 0, 0);

    cla_bist_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_o(a1), .b_o(b1), .c0_o(c01),
        .sum_i(s1), .c4_i(c41), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_valid(fv1), .fail_vec(fvec1)
    );

    cla_bist_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_o(a3), .b_o(b3), .c0_o(c03),
        .sum_i(s3), .c4_i(c43), .busy(busy3), .done(done3), .pass(pass3),
        .err_cnt(err3), .fail_valid(fv3), .fail_vec(fvec3)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: walk every operand combination and count where the adder
    // differs from true integer addition.
    function automatic exp_t model(input int mode, input int bidx, input int settle);
        exp_t e;
        e.err = 0; e.fv = 0; e.fvec = 0;
        for (int v = 0; v < 512; v++) begin
            int a, b, c;
            a = v % 16; b = (v / 16) % 16; c = v / 256;
            if (int'(adder(a, b, c, mode, bidx)) != a + b + c) begin
                if (e.fv == 0) e.fvec = v;
                e.fv = 1;
                e.err++;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        e.lat = 512 * (settle + 1) + 1;
        e.start_cyc = cyc;
        return e;
    endfunction

    always begin
        exp_t e;
        @(negedge clk);
        if (!rst && done1) begin
            if (q1.size() == 0) chk("spurious_done1", 1, 0);
            else begin
                e = q1.pop_front();
                chk("lat1", cyc - e.start_cyc, e.lat);
                chk("err1", int'(err1), e.err);
                chk("fv1", int'(fv1), e.fv);
                chk("fvec1", int'(fvec1), e.fvec);
                chk("busy_at_done1", int'(busy1), 0);
                @(negedge clk);
                chk("done_pulse1", int'(done1), 0);
                chk("pass1", int'(pass1), e.pass);
                repeat (3) @(negedge clk);
                chk("hold_err1", int'(err1), e.err);
                chk("hold_pass1", int'(pass1), e.pass);
                retired1++;
            end
        end
    end

    always begin
        exp_t e;
        @(negedge clk);
        if (!rst && done3) begin
            if (q3.size() == 0) chk("spurious_done3", 1, 0);
            else begin
                e = q3.pop_front();
                chk("lat3", cyc - e.start_cyc, e.lat);
                chk("err3", int'(err3), e.err);
                @(negedge clk);
                chk("pass3", int'(pass3), e.pass);
                retired3++;
            end
        end
    end

    task automatic run1(input int mode, input bit also3);
        @(negedge clk);
        fmode = mode;
        if (mode == 3) bad_idx = $urandom_range(0, 511);
        q1.push_back(model(fmode, bad_idx, 1));
        issued1++;
        start1 = 1'b1;
        if (also3) begin
            q3.push_back(model(0, 0, 3));
            issued3++;
            start3 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((retired1 != issued1 || retired3 != issued3) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) chk("run_timeout", 1, 0);
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (int'({c01, b1, a1}) != target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("idx_timeout", 1, 0);
    endtask

    task automatic chk_reset1();
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_pass", int'(pass1), 0);
        chk("rst_err", int'(err1), 0);
        chk("rst_fv", int'(fv1), 0);
        chk("rst_fvec", int'(fvec1), 0);
        chk("rst_ops", int'({c01, b1, a1}), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset1();
        chk("rst_busy3", int'(busy3), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run1(0, 1'b1);
        wait_idle();
        run1(1, 1'b0);
        wait_idle();
        run1(2, 1'b0);
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            run1(3, 1'b0);
            wait_idle();
        end

        // Start re-pulsed mid-run must not disturb timing or results.
        run1(2, 1'b0);
        wait_idx(50);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("restart_busy", int'(busy1), 1);
        wait_idle();

        // Abort mid-run: outputs clear immediately and no done follows.
        run1(1, 1'b0);
        wait_idx(100);
        rst = 1'b1;
        #1;
        chk_reset1();
        void'(q1.pop_front());
        issued1--;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_idle_busy", int'(busy1), 0);
        run1(0, 1'b0);
        @(negedge clk);
        chk("restart_idx0", int'({c01, b1, a1}), 0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
